tl45_rf_wb_arbiter: RTL and testbench
=====================================

Name: tl45_rf_wb_arbiter

Overview:
Shares the single write port of the TL45 register file between two writeback sources: src0 (ALU pipe) and src1 (memory/load unit). It also keeps a per-register pending-write scoreboard, so decode can stall on registers that are still in flight. It sits between the execute/memory stages and the register file, and drives that file's wrREG / writeAdd / dataI inputs.

Parameters:
CNT_W, 2, width of each per-register pending-write counter; saturates at 2^CNT_W-1.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
iss_valid  input  1  decode issues an instruction that will write iss_reg
iss_reg  input  4  destination register of the issued instruction
iss_ready  output  1  issue accepted this cycle (combinational)
s0_valid  input  1  ALU writeback request
s0_reg  input  4  ALU destination register
s0_data  input  32  ALU result
s0_ready  output  1  ALU request accepted this cycle
s1_valid  input  1  memory writeback request
s1_reg  input  4  memory destination register
s1_data  input  32  load data
s1_ready  output  1  memory request accepted this cycle
rf_wr_en  output  1  to register file wrREG
rf_wr_addr  output  4  to register file writeAdd
rf_wr_data  output  32  to register file dataI
busy  output  16  busy[i]=1 when counter[i]!=0; busy[0] always 0

Behaviour:
- Reset: synchronous, active-high; clock clk. All slots invalid, all counters 0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, last_grant=1 (src0 wins the first contest).
- Reset mid-operation discards slot contents and pending counts.
- Each source has a one-entry holding slot (valid, reg, data).
- sN_ready = !slotN_valid || slotN granted this cycle.
- A slot loads on the edge where sN_valid && sN_ready.
- Arbitration is combinational over valid slots:
  - only one valid: grant it;
  - both valid: grant the source != last_grant, then last_grant updates to the granted source.
- Granted slot loads the output register at the next edge:
  - rf_wr_en=1, rf_wr_addr=slot reg, rf_wr_data=slot data for exactly one cycle;
  - with no grant, rf_wr_en=0 and addr/data hold their previous values.
- Latency: accept at edge N -> rf_wr_en high in cycle after edge N+1 -> register file written at edge N+2. Sustained throughput is one write per cycle total.
- Writes to r0 still pass through arbitration and drive rf_wr_en. The register file ignores them and the scoreboard ignores them.
- Scoreboard, registers 1..15 (index 0 is unused):
  - Increment counter[iss_reg] on the edge of iss_valid && iss_ready && iss_reg!=0.
  - Decrement counter[rf_wr_addr] on the edge where rf_wr_en=1 && rf_wr_addr!=0, i.e. the same edge the register file writes.
  - Increment and decrement to the same register on the same edge: counter unchanged.
  - Decrement at 0: counter stays 0. This is a protocol violation and is not flagged.
- iss_ready = 0 only when iss_reg!=0 and counter[iss_reg]==2^CNT_W-1 with no same-edge decrement to that register; otherwise 1.
- The arbiter does not enforce program order between sources. Issue ordering of same-register writes is the producers' responsibility.

Optional Feature:
TL45_WBARB_FIXED_PRIO_EN
- Defined: src1 (memory) always wins when both slots are valid; last_grant is unused. src0 can starve while src1 streams.
- Undefined: round-robin as described above.

Test Plan:
- Single write: iss r3, then s0 {r3, 0xDEADBEEF} -> busy[3]=1 after the issue edge; rf_wr_en=1, addr=3, data=0xDEADBEEF 2 cycles after accept; busy[3]=0 one edge later.
- Contention: s0 {r1, 0x11} and s1 {r2, 0x22} valid in the same cycle, held for 3 requests each -> writes alternate r1,r2,r1,r2,r1,r2 starting with r1. With TL45_WBARB_FIXED_PRIO_EN, all r2 writes precede the r1 writes.
- Backpressure: both slots full and s0 re-presents -> s0_ready=0 until slot0 is granted; no request lost; data order within each source preserved.
- Saturation (CNT_W=2): 3 issues to r5 -> iss_ready=0 on the 4th. Same cycle as a commit to r5 -> iss_ready=1 and counter stays 3.
- r0 handling: iss r0 x4 -> iss_ready stays 1, busy=0. s0 {r0, 0x5} -> rf_wr_en pulses with addr 0; no counter change.
- Reset mid-flight: reset asserted while slot1 is valid and busy[7]=1 -> next cycle busy=0, rf_wr_en=0, s0_ready=s1_ready=1.

Source files
------------

// File: rtl/tl45_rf_wb_arbiter_if.sv
// Writeback bus between the execute/memory producers, decode issue and the
// register-file write-port arbiter.
interface tl45_rf_wb_arbiter_if;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 16;

  logic              iss_valid;
  logic [REG_W-1:0]  iss_reg;
  logic              iss_ready;

  logic              s0_valid;
  logic [REG_W-1:0]  s0_reg;
  logic [DATA_W-1:0] s0_data;
  logic              s0_ready;

  logic              s1_valid;
  logic [REG_W-1:0]  s1_reg;
  logic [DATA_W-1:0] s1_data;
  logic              s1_ready;

  logic              rf_wr_en;
  logic [REG_W-1:0]  rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [NREG-1:0]   busy;

  modport slave (
    input  iss_valid, iss_reg, s0_valid, s0_reg, s0_data, s1_valid, s1_reg, s1_data,
    output iss_ready, s0_ready, s1_ready, rf_wr_en, rf_wr_addr, rf_wr_data, busy
  );

  modport master (
    output iss_valid, iss_reg, s0_valid, s0_reg, s0_data, s1_valid, s1_reg, s1_data,
    input  iss_ready, s0_ready, s1_ready, rf_wr_en, rf_wr_addr, rf_wr_data, busy
  );
endinterface

// File: rtl/tl45_rf_wb_arbiter.sv
// TL45 register-file write-port arbiter (ALU vs. load unit) with a per-register
// pending-write scoreboard. Define TL45_WBARB_FIXED_PRIO_EN to give src1 fixed priority.
module tl45_rf_wb_arbiter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  tl45_rf_wb_arbiter_if.slave        bus
);
  localparam int unsigned REG_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              slot0_valid, slot1_valid;
  logic [REG_W-1:0]  slot0_reg, slot1_reg;
  logic [DATA_W-1:0] slot0_data, slot1_data;

  logic              wr_en_q;
  logic [REG_W-1:0]  wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic [CNT_W-1:0]  cnt [NREG];

  logic              grant0_c, grant1_c;
  logic              s0_ready_c, s1_ready_c, iss_ready_c;
  logic              inc_c, dec_c;
  logic [NREG-1:0]   inc_vec_c, dec_vec_c, busy_c;

`ifdef TL45_WBARB_FIXED_PRIO_EN
  // Memory side always wins a contest
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    grant1_c = slot1_valid;
    grant0_c = slot0_valid && !slot1_valid;
  end
`else
  logic last_grant;

  // Round-robin: on contention the source that did not win last time goes
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (slot0_valid && slot1_valid) begin
      grant0_c = last_grant;
      grant1_c = !last_grant;
    end else begin
      grant0_c = slot0_valid;
      grant1_c = slot1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (slot0_valid && slot1_valid) begin
      last_grant <= grant1_c;
    end
  end
`endif

  assign s0_ready_c = !slot0_valid || grant0_c;
  assign s1_ready_c = !slot1_valid || grant1_c;

  // Holding slots: a granted slot may be refilled on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_valid <= 1'b0;
      slot0_reg   <= '0;
      slot0_data  <= '0;
      slot1_valid <= 1'b0;
      slot1_reg   <= '0;
      slot1_data  <= '0;
    end else begin
      if (bus.s0_valid && s0_ready_c) begin
        slot0_valid <= 1'b1;
        slot0_reg   <= bus.s0_reg;
        slot0_data  <= bus.s0_data;
      end else if (grant0_c) begin
        slot0_valid <= 1'b0;
      end
      if (bus.s1_valid && s1_ready_c) begin
        slot1_valid <= 1'b1;
        slot1_reg   <= bus.s1_reg;
        slot1_data  <= bus.s1_data;
      end else if (grant1_c) begin
        slot1_valid <= 1'b0;
      end
    end
  end

  // Register-file write register; addr/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= grant0_c || grant1_c;
      if (grant1_c) begin
        wr_addr_q <= slot1_reg;
        wr_data_q <= slot1_data;
      end else if (grant0_c) begin
        wr_addr_q <= slot0_reg;
        wr_data_q <= slot0_data;
      end
    end
  end

  assign dec_c       = wr_en_q && (wr_addr_q != '0);
  assign iss_ready_c = !((bus.iss_reg != '0) && (cnt[bus.iss_reg] == CNT_MAX) &&
                         !(dec_c && (wr_addr_q == bus.iss_reg)));
  assign inc_c       = bus.iss_valid && iss_ready_c && (bus.iss_reg != '0);

  always_comb begin
    inc_vec_c = '0;
    dec_vec_c = '0;
    busy_c    = '0;
    if (inc_c) inc_vec_c = NREG'(1) << bus.iss_reg;
    if (dec_c) dec_vec_c = NREG'(1) << wr_addr_q;
    for (int unsigned i = 1; i < NREG; i++) begin
      busy_c[i] = (cnt[i] != '0);
    end
  end

  // Pending-write counters; r0 is never tracked, same-edge inc/dec cancel
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (inc_vec_c[i] && !dec_vec_c[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (dec_vec_c[i] && !inc_vec_c[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  assign bus.iss_ready  = iss_ready_c;
  assign bus.s0_ready   = s0_ready_c;
  assign bus.s1_ready   = s1_ready_c;
  assign bus.rf_wr_en   = wr_en_q;
  assign bus.rf_wr_addr = wr_addr_q;
  assign bus.rf_wr_data = wr_data_q;
  assign bus.busy       = busy_c;
endmodule

// File: tb/tb_tl45_rf_wb_arbiter.sv
// Self-checking bench for tl45_rf_wb_arbiter: directed vector table, contention and
// mid-flight reset sequences, then random traffic against a queue-based reference model.
module tb_tl45_rf_wb_arbiter;
  localparam int CNT_MAX = 3;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [31:0] Z  = 32'd0;
  localparam logic [31:0] DB = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tl45_rf_wb_arbiter_if bus();
  tl45_rf_wb_arbiter #(.CNT_W(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic        iv;
    logic [3:0]  ir;
    logic        v0;
    logic [3:0]  r0;
    logic [31:0] d0;
    logic        v1;
    logic [3:0]  r1;
    logic [31:0] d1;
    logic        e_iss;
    logic        e_s0r;
    logic        e_s1r;
    logic        e_wen;
    logic [3:0]  e_addr;
    logic [31:0] e_data;
    logic [15:0] e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic iv, input logic [3:0] ir,
                              input logic v0, input logic [3:0] r0, input logic [31:0] d0,
                              input logic v1, input logic [3:0] r1, input logic [31:0] d1,
                              input logic ei, input logic e0, input logic e1,
                              input logic ew, input logic [3:0] ea, input logic [31:0] ed,
                              input logic [15:0] eb);
    vec_t v;
    v.iv = iv; v.ir = ir; v.v0 = v0; v.r0 = r0; v.d0 = d0; v.v1 = v1; v.r1 = r1; v.d1 = d1;
    v.e_iss = ei; v.e_s0r = e0; v.e_s1r = e1; v.e_wen = ew; v.e_addr = ea; v.e_data = ed;
    v.e_busy = eb;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [3:0] ir,
                       input logic v0, input logic [3:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [3:0] r1, input logic [31:0] d1);
    bus.iss_valid = iv; bus.iss_reg = ir;
    bus.s0_valid = v0; bus.s0_reg = r0; bus.s0_data = d0;
    bus.s1_valid = v1; bus.s1_reg = r1; bus.s1_data = d1;
  endtask

  task automatic idle();
    drive(F, 4'd0, F, 4'd0, Z, F, 4'd0, Z);
  endtask

  // Reference model: one queue per producer slot, a pending write, plain int counters
  logic [35:0] mq0[$];
  logic [35:0] mq1[$];
  int          mlg;
  logic        mwen;
  logic [3:0]  mwaddr;
  logic [31:0] mwdata;
  int          mcnt[16];

  task automatic model_reset();
    mq0.delete(); mq1.delete();
    mlg = 1; mwen = 1'b0; mwaddr = 4'd0; mwdata = 32'd0;
    for (int i = 0; i < 16; i++) mcnt[i] = 0;
  endtask

  function automatic int model_grant();
`ifdef TL45_WBARB_FIXED_PRIO_EN
    if (mq1.size() > 0) return 1;
    if (mq0.size() > 0) return 0;
    return -1;
`else
    if (mq0.size() > 0 && mq1.size() > 0) return (mlg == 1) ? 0 : 1;
    if (mq0.size() > 0) return 0;
    if (mq1.size() > 0) return 1;
    return -1;
`endif
  endfunction

  function automatic logic [15:0] model_busy();
    logic [15:0] b;
    b = 16'd0;
    for (int i = 1; i < 16; i++) b[i] = (mcnt[i] != 0);
    return b;
  endfunction

  logic [35:0] wq[$];
  logic [35:0] exp_w[6];
  int n0, n1, g, ireg, dreg;
  logic a0, a1, rst, e_r0, e_r1, e_iss, both;
  logic iv, v0, v1;
  logic [3:0] ir, r0, r1;
  logic [31:0] d0, d1;

  initial begin
    // Power-on reset
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", 32'(bus.rf_wr_en), 32'd0);
    chk("rst_addr", 32'(bus.rf_wr_addr), 32'd0);
    chk("rst_data", bus.rf_wr_data, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_s0_ready", 32'(bus.s0_ready), 32'd1);
    chk("rst_s1_ready", 32'(bus.s1_ready), 32'd1);
    chk("rst_iss_ready", 32'(bus.iss_ready), 32'd1);
    reset = 1'b0;

    // Single write, saturation, r0 handling
    tbl.push_back(mk(T,4'd3, F,4'd0,Z, F,4'd0,Z,          T,T,T, F,4'd0,Z,  16'h0008));
    tbl.push_back(mk(F,4'd0, T,4'd3,DB, F,4'd0,Z,         T,T,T, F,4'd0,Z,  16'h0008));
    tbl.push_back(mk(F,4'd0, F,4'd0,Z, F,4'd0,Z,          T,T,T, T,4'd3,DB, 16'h0008));
    tbl.push_back(mk(F,4'd0, F,4'd0,Z, F,4'd0,Z,          T,T,T, F,4'd3,DB, 16'h0000));
    tbl.push_back(mk(T,4'd5, F,4'd0,Z, F,4'd0,Z,          T,T,T, F,4'd3,DB, 16'h0020));
    tbl.push_back(mk(T,4'd5, F,4'd0,Z, F,4'd0,Z,          T,T,T, F,4'd3,DB, 16'h0020));
    tbl.push_back(mk(T,4'd5, F,4'd0,Z, F,4'd0,Z,          T,T,T, F,4'd3,DB, 16'h0020));
    tbl.push_back(mk(T,4'd5, F,4'd0,Z, F,4'd0,Z,          F,T,T, F,4'd3,DB, 16'h0020));
    tbl.push_back(mk(T,4'd5, F,4'd0,Z, T,4'd5,32'h55,     F,T,T, F,4'd3,DB, 16'h0020));
    tbl.push_back(mk(T,4'd5, F,4'd0,Z, F,4'd0,Z,          F,T,T, T,4'd5,32'h55, 16'h0020));
    tbl.push_back(mk(T,4'd5, F,4'd0,Z, F,4'd0,Z,          T,T,T, F,4'd5,32'h55, 16'h0020));
    tbl.push_back(mk(T,4'd5, F,4'd0,Z, F,4'd0,Z,          F,T,T, F,4'd5,32'h55, 16'h0020));
    tbl.push_back(mk(T,4'd0, F,4'd0,Z, F,4'd0,Z,          T,T,T, F,4'd5,32'h55, 16'h0020));
    tbl.push_back(mk(T,4'd0, T,4'd0,32'h5, F,4'd0,Z,      T,T,T, F,4'd5,32'h55, 16'h0020));
    tbl.push_back(mk(T,4'd0, F,4'd0,Z, F,4'd0,Z,          T,T,T, T,4'd0,32'h5, 16'h0020));
    tbl.push_back(mk(F,4'd0, F,4'd0,Z, F,4'd0,Z,          T,T,T, F,4'd0,32'h5, 16'h0020));

    foreach (tbl[k]) begin
      drive(tbl[k].iv, tbl[k].ir, tbl[k].v0, tbl[k].r0, tbl[k].d0,
            tbl[k].v1, tbl[k].r1, tbl[k].d1);
      #1;
      chk($sformatf("vec%0d_iss_ready", k), 32'(bus.iss_ready), 32'(tbl[k].e_iss));
      chk($sformatf("vec%0d_s0_ready", k), 32'(bus.s0_ready), 32'(tbl[k].e_s0r));
      chk($sformatf("vec%0d_s1_ready", k), 32'(bus.s1_ready), 32'(tbl[k].e_s1r));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_wen", k), 32'(bus.rf_wr_en), 32'(tbl[k].e_wen));
      chk($sformatf("vec%0d_addr", k), 32'(bus.rf_wr_addr), 32'(tbl[k].e_addr));
      chk($sformatf("vec%0d_data", k), bus.rf_wr_data, tbl[k].e_data);
      chk($sformatf("vec%0d_busy", k), 32'(bus.busy), 32'(tbl[k].e_busy));
    end

    // Reset while slot1 holds a write and r7 is pending
    drive(T, 4'd7, F, 4'd0, Z, T, 4'd7, 32'h77);
    @(posedge clk);
    #1;
    chk("midrst_busy7_before", 32'(bus.busy[7]), 32'd1);
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_wen", 32'(bus.rf_wr_en), 32'd0);
    chk("midrst_s0_ready", 32'(bus.s0_ready), 32'd1);
    chk("midrst_s1_ready", 32'(bus.s1_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_no_stale_write", 32'(bus.rf_wr_en), 32'd0);

    // Contention: three requests from each producer presented back to back
`ifdef TL45_WBARB_FIXED_PRIO_EN
    exp_w[0] = {4'd2, 32'h200}; exp_w[1] = {4'd2, 32'h201}; exp_w[2] = {4'd2, 32'h202};
    exp_w[3] = {4'd1, 32'h100}; exp_w[4] = {4'd1, 32'h101}; exp_w[5] = {4'd1, 32'h102};
`else
    exp_w[0] = {4'd1, 32'h100}; exp_w[1] = {4'd2, 32'h200}; exp_w[2] = {4'd1, 32'h101};
    exp_w[3] = {4'd2, 32'h201}; exp_w[4] = {4'd1, 32'h102}; exp_w[5] = {4'd2, 32'h202};
`endif
    n0 = 0; n1 = 0;
    wq.delete();
    for (int c = 0; c < 40 && wq.size() < 6; c++) begin
      drive(F, 4'd0, (n0 < 3), 4'd1, 32'h100 + 32'(n0), (n1 < 3), 4'd2, 32'h200 + 32'(n1));
      #1;
      if (c == 1) begin
`ifdef TL45_WBARB_FIXED_PRIO_EN
        chk("cont_s0_ready_full", 32'(bus.s0_ready), 32'd0);
        chk("cont_s1_ready_full", 32'(bus.s1_ready), 32'd1);
`else
        chk("cont_s0_ready_full", 32'(bus.s0_ready), 32'd1);
        chk("cont_s1_ready_full", 32'(bus.s1_ready), 32'd0);
`endif
      end
      a0 = bus.s0_valid && bus.s0_ready;
      a1 = bus.s1_valid && bus.s1_ready;
      @(posedge clk);
      if (a0) n0++;
      if (a1) n1++;
      #1;
      if (bus.rf_wr_en) wq.push_back({bus.rf_wr_addr, bus.rf_wr_data});
    end
    chk("cont_write_count", 32'(wq.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < wq.size()) begin
        chk($sformatf("cont_w%0d_addr", i), 32'(wq[i][35:32]), 32'(exp_w[i][35:32]));
        chk($sformatf("cont_w%0d_data", i), wq[i][31:0], exp_w[i][31:0]);
      end
    end
    idle();

    // Random traffic against the reference model
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = (cyc == 0) || ($urandom_range(0, 299) == 0);
      iv = ($urandom_range(0, 3) != 0);
      ir = 4'($urandom_range(0, 4));
      v0 = ($urandom_range(0, 2) != 0);
      r0 = 4'($urandom_range(0, 6));
      d0 = $urandom;
      v1 = ($urandom_range(0, 2) != 0);
      r1 = 4'($urandom_range(0, 6));
      d1 = $urandom;
      reset = rst;
      drive(iv, ir, v0, r0, d0, v1, r1, d1);
      #1;
      g = model_grant();
      e_r0 = (mq0.size() == 0) || (g == 0);
      e_r1 = (mq1.size() == 0) || (g == 1);
      e_iss = !((ir != 4'd0) && (mcnt[ir] == CNT_MAX) && !(mwen && (mwaddr == ir)));
      chk($sformatf("rnd%0d_s0_ready", cyc), 32'(bus.s0_ready), 32'(e_r0));
      chk($sformatf("rnd%0d_s1_ready", cyc), 32'(bus.s1_ready), 32'(e_r1));
      chk($sformatf("rnd%0d_iss_ready", cyc), 32'(bus.iss_ready), 32'(e_iss));
      @(posedge clk);
      if (rst) begin
        model_reset();
      end else begin
        dreg = (mwen && (mwaddr != 4'd0)) ? int'(mwaddr) : -1;
        ireg = (iv && e_iss && (ir != 4'd0)) ? int'(ir) : -1;
        if (ireg != dreg) begin
          if (ireg > 0) mcnt[ireg]++;
          if (dreg > 0 && mcnt[dreg] > 0) mcnt[dreg]--;
        end
        both = (mq0.size() > 0) && (mq1.size() > 0);
        if (g == 0) begin
          mwen = 1'b1;
          {mwaddr, mwdata} = mq0.pop_front();
        end else if (g == 1) begin
          mwen = 1'b1;
          {mwaddr, mwdata} = mq1.pop_front();
        end else begin
          mwen = 1'b0;
        end
        if (both) mlg = g;
        if (v0 && e_r0) mq0.push_back({r0, d0});
        if (v1 && e_r1) mq1.push_back({r1, d1});
      end
      #1;
      chk($sformatf("rnd%0d_wen", cyc), 32'(bus.rf_wr_en), 32'(mwen));
      chk($sformatf("rnd%0d_addr", cyc), 32'(bus.rf_wr_addr), 32'(mwaddr));
      chk($sformatf("rnd%0d_data", cyc), bus.rf_wr_data, mwdata);
      chk($sformatf("rnd%0d_busy", cyc), 32'(bus.busy), 32'(model_busy()));
    end
    reset = 1'b0;
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
